// File: rtl/cnn_mem_master.sv
// Bus initiator for the cnn_mem peripheral port: streams load bytes into region writes and
// readback commands into indexed reads, returning read bytes through a small output FIFO.
module cnn_mem_master #(
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned LEN_W       = 19,
  parameter int unsigned NUM_REGIONS = 5,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_op_i,
  input  logic [2:0]        cmd_region_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              done_o,
  output logic              cmd_err_o,
  output logic              mem_chipselect_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_writedata_o,
  input  logic [DATA_W-1:0] mem_readdata_i
);

  localparam int unsigned DEPTH = RD_LATENCY + 1;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = $clog2(2 * DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ, S_FLUSH} state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d, len_q, len_d;
  logic [2:0]          region_q, region_d;
  logic                cmd_ready_q, cmd_ready_d, in_ready_q, in_ready_d;
  logic                done_q, done_d, err_q, err_d;
  logic                cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [RD_LATENCY:0] pipe_q, pipe_d;
  logic [DATA_W-1:0]   fifo_mem_q [DEPTH];
  logic [DATA_W-1:0]   fifo_mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [SUM_W-1:0]    occ;
  logic                cmd_acc, in_acc, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign cmd_acc = cmd_valid_i & cmd_ready_q;
  assign in_acc  = in_valid_i & in_ready_q;
  assign push    = pipe_q[RD_LATENCY];
  assign pop     = out_valid_q & out_ready_i;

  // Bytes already buffered plus reads still in flight; bounds read issue so the FIFO never overflows.
  always_comb begin
    occ = SUM_W'(fifo_cnt_q);
    for (int unsigned k = 0; k <= RD_LATENCY; k++) begin
      occ = occ + SUM_W'(pipe_q[k]);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    region_d = region_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cs_d     = 1'b0;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    addr_d   = '0;
    wdata_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          cnt_d    = '0;
          len_d    = cmd_len_i;
          region_d = cmd_region_i;
          if (cmd_len_i == '0) begin
            done_d = 1'b1;
          end else if (!cmd_op_i && (32'(cmd_region_i) >= NUM_REGIONS)) begin
            err_d = 1'b1;
          end else if (!cmd_op_i) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_LOAD: begin
        if (in_acc) begin
          cnt_d   = cnt_q + LEN_W'(1);
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          addr_d  = ADDR_W'(region_q);
          wdata_d = in_data_i;
        end else if (cnt_q == len_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if ((cnt_q != len_q) && (occ < SUM_W'(DEPTH))) begin
          cs_d   = 1'b1;
          rd_d   = 1'b1;
          addr_d = ADDR_W'(cnt_q);
          cnt_d  = cnt_q + LEN_W'(1);
        end
        if (cnt_d == len_q) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if ((pipe_q == '0) && (fifo_cnt_q == '0)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    cmd_ready_d = (state_d == S_IDLE);
    in_ready_d  = (state_d == S_LOAD) && (cnt_d != len_d);
  end

  // Read-capture shift register and output FIFO bookkeeping.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = rd_d;
    for (int unsigned k = 1; k <= RD_LATENCY; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = mem_readdata_i;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    end else if (!push && pop) begin
      fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
    end
    out_valid_d = (fifo_cnt_d != '0);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      region_q    <= '0;
      cmd_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cs_q        <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      pipe_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      region_q    <= region_d;
      cmd_ready_q <= cmd_ready_d;
      in_ready_q  <= in_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cs_q        <= cs_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      pipe_q      <= pipe_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      out_valid_q <= out_valid_d;
      fifo_mem_q  <= fifo_mem_d;
    end
  end

  assign cmd_ready_o      = cmd_ready_q;
  assign in_ready_o       = in_ready_q;
  assign out_valid_o      = out_valid_q;
  assign out_data_o       = fifo_mem_q[rd_ptr_q];
  assign done_o           = done_q;
  assign cmd_err_o        = err_q;
  assign mem_chipselect_o = cs_q;
  assign mem_write_o      = wr_q;
  assign mem_read_o       = rd_q;
  assign mem_address_o    = addr_q;
  assign mem_writedata_o  = wdata_q;

endmodule

// File: tb/tb_cnn_mem_master.sv
// Directed bench for cnn_mem_master with a latency-1 memory model returning 0xA0+address.
module tb_cnn_mem_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [2:0]  cmd_region;
  logic [18:0] cmd_len;
  logic [7:0]  in_data;
  logic        in_valid, in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_ready;
  logic        done, cmd_err;
  logic        mem_cs, mem_write, mem_read;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] ld_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] rb [4];
  int         got;
  logic       seen_done;

  cnn_mem_master dut (
    .clk_i(clk), .reset_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_region_i(cmd_region), .cmd_len_i(cmd_len),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .done_o(done), .cmd_err_o(cmd_err),
    .mem_chipselect_o(mem_cs), .mem_write_o(mem_write), .mem_read_o(mem_read),
    .mem_address_o(mem_addr), .mem_writedata_o(mem_wdata), .mem_readdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rdata <= mem_read ? (8'hA0 + mem_addr[7:0]) : 8'h00;
  end

  // Bus and status exclusivity checked every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      n_assert++;
      assert (!(mem_write && mem_read)) else begin
        n_fail++;
        $error("FAIL wr_rd_overlap: observed wr=%0b rd=%0b expected not both", mem_write, mem_read);
      end
      n_assert++;
      assert (!(done && cmd_err)) else begin
        n_fail++;
        $error("FAIL done_err_overlap: observed done=%0b err=%0b expected not both", done, cmd_err);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_region = '0; cmd_len = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_cs", 32'(mem_cs), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(cmd_err), 32'd0);
    step; step;
    rst = 1'b0;

    // Load region 1, four back-to-back bytes
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_region = 3'd1; cmd_len = 19'd4;
    step;
    cmd_valid = 1'b0;
    chk("ld_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("ld_in_ready", 32'(in_ready), 32'd1);
    chk("ld_idle_bus", 32'(mem_cs), 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = ld_bytes[i];
      step;
      chk($sformatf("ld_wr%0d", i), 32'(mem_write), 32'd1);
      chk($sformatf("ld_cs%0d", i), 32'(mem_cs), 32'd1);
      chk($sformatf("ld_addr%0d", i), 32'(mem_addr), 32'd1);
      chk($sformatf("ld_data%0d", i), 32'(mem_wdata), 32'(ld_bytes[i]));
      chk($sformatf("ld_inrdy%0d", i), 32'(in_ready), (i < 3) ? 32'd1 : 32'd0);
      chk($sformatf("ld_nodone%0d", i), 32'(done), 32'd0);
    end
    in_valid = 1'b0;
    step;
    chk("ld_done", 32'(done), 32'd1);
    chk("ld_done_bus", 32'(mem_cs), 32'd0);
    chk("ld_done_cmd_ready", 32'(cmd_ready), 32'd1);
    step;
    chk("ld_done_pulse", 32'(done), 32'd0);

    // Readback len 3 with consumer stalled
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_region = 3'd0; cmd_len = 19'd3; out_ready = 1'b0;
    step;
    cmd_valid = 1'b0;
    chk("rb_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rb_r1_rd", 32'(mem_read), 32'd0);
    step;
    chk("rb_r2_rd", 32'(mem_read), 32'd1);
    chk("rb_r2_cs", 32'(mem_cs), 32'd1);
    chk("rb_r2_addr", 32'(mem_addr), 32'd0);
    step;
    chk("rb_r3_rd", 32'(mem_read), 32'd1);
    chk("rb_r3_addr", 32'(mem_addr), 32'd1);
    chk("rb_r3_ov", 32'(out_valid), 32'd0);
    step;
    chk("rb_r4_stall", 32'(mem_read), 32'd0);
    chk("rb_r4_ov", 32'(out_valid), 32'd1);
    chk("rb_r4_data", 32'(out_data), 32'hA0);
    step;
    chk("rb_r5_stall", 32'(mem_cs), 32'd0);
    chk("rb_r5_data", 32'(out_data), 32'hA0);
    step;
    chk("rb_r6_stall", 32'(mem_read), 32'd0);
    out_ready = 1'b1;
    step;
    chk("rb_r7_ov", 32'(out_valid), 32'd1);
    chk("rb_r7_data", 32'(out_data), 32'hA1);
    chk("rb_r7_rd", 32'(mem_read), 32'd0);
    step;
    chk("rb_r8_rd", 32'(mem_read), 32'd1);
    chk("rb_r8_addr", 32'(mem_addr), 32'd2);
    chk("rb_r8_ov", 32'(out_valid), 32'd0);
    step;
    chk("rb_r9_ov", 32'(out_valid), 32'd0);
    chk("rb_r9_done", 32'(done), 32'd0);
    step;
    chk("rb_r10_ov", 32'(out_valid), 32'd1);
    chk("rb_r10_data", 32'(out_data), 32'hA2);
    chk("rb_r10_done", 32'(done), 32'd0);
    step;
    chk("rb_r11_ov", 32'(out_valid), 32'd0);
    chk("rb_r11_done", 32'(done), 32'd0);
    step;
    chk("rb_done", 32'(done), 32'd1);
    chk("rb_done_cmd_ready", 32'(cmd_ready), 32'd1);
    out_ready = 1'b0;

    // Zero-length load and readback
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_region = 3'd1; cmd_len = 19'd0;
    step;
    cmd_valid = 1'b0;
    chk("z0_done", 32'(done), 32'd1);
    chk("z0_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("z0_bus", 32'(mem_cs), 32'd0);
    chk("z0_in_ready", 32'(in_ready), 32'd0);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_len = 19'd0;
    step;
    cmd_valid = 1'b0;
    chk("z1_done", 32'(done), 32'd1);
    chk("z1_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("z1_bus", 32'(mem_cs), 32'd0);
    step;
    chk("z1_done_pulse", 32'(done), 32'd0);
    chk("z1_bus_after", 32'(mem_cs), 32'd0);

    // Load to invalid region 5
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_region = 3'd5; cmd_len = 19'd2;
    step;
    cmd_valid = 1'b0;
    chk("er_err", 32'(cmd_err), 32'd1);
    chk("er_done", 32'(done), 32'd0);
    chk("er_in_ready", 32'(in_ready), 32'd0);
    chk("er_cmd_ready", 32'(cmd_ready), 32'd1);
    step;
    chk("er_err_pulse", 32'(cmd_err), 32'd0);
    chk("er_in_ready2", 32'(in_ready), 32'd0);
    chk("er_no_wr", 32'(mem_write), 32'd0);

    // Reset in the middle of a load
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_region = 3'd2; cmd_len = 19'd4;
    step;
    cmd_valid = 1'b0;
    in_valid = 1'b1; in_data = 8'h01;
    step;
    in_data = 8'h02;
    step;
    chk("mr_wr_before", 32'(mem_write), 32'd1);
    chk("mr_addr_before", 32'(mem_addr), 32'd2);
    #2 rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("mr_cs", 32'(mem_cs), 32'd0);
    chk("mr_wr", 32'(mem_write), 32'd0);
    chk("mr_wdata", 32'(mem_wdata), 32'd0);
    chk("mr_in_ready", 32'(in_ready), 32'd0);
    chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
    step; step;
    rst = 1'b0;
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_region = 3'd3; cmd_len = 19'd1;
    step;
    cmd_valid = 1'b0;
    chk("mr2_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 8'h5A;
    step;
    in_valid = 1'b0;
    chk("mr2_wr", 32'(mem_write), 32'd1);
    chk("mr2_addr", 32'(mem_addr), 32'd3);
    chk("mr2_data", 32'(mem_wdata), 32'h5A);
    chk("mr2_in_ready0", 32'(in_ready), 32'd0);
    step;
    chk("mr2_done", 32'(done), 32'd1);

    // Load immediately followed by readback (region field ignored for readback)
    step;
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_region = 3'd4; cmd_len = 19'd2;
    step;
    cmd_valid = 1'b0;
    in_valid = 1'b1; in_data = 8'h01;
    step;
    chk("bb_wr0_addr", 32'(mem_addr), 32'd4);
    in_data = 8'h02;
    step;
    chk("bb_wr1_data", 32'(mem_wdata), 32'h02);
    in_valid = 1'b0;
    step;
    chk("bb_ld_done", 32'(done), 32'd1);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_region = 3'd7; cmd_len = 19'd2; out_ready = 1'b1;
    step;
    cmd_valid = 1'b0;
    got = 0;
    seen_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (out_valid) begin
        if (got < 4) rb[got] = out_data;
        got++;
      end
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      step;
    end
    chk("bb_done_seen", 32'(seen_done), 32'd1);
    chk("bb_count", 32'(got), 32'd2);
    chk("bb_byte0", 32'(rb[0]), 32'hA0);
    chk("bb_byte1", 32'(rb[1]), 32'hA1);
    chk("bb_cmd_ready", 32'(cmd_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
